ff_array_mp: RTL and testbench
==============================

FF_ARRAY_MP -- requirements
Module: ff_array_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, entry data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width in bits.
REQ-003 SHALL have parameter DATA_N, default 8, number of entries; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter RD_PORTS, default 2, number of independent read ports; legal range >= 1.
REQ-005 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (1 = on, 0 = off).
REQ-006 SHALL have port clk  input  1  single clock, rising-edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port waddr  input  ADDR_W  write address.
REQ-010 SHALL have port din  input  DATA_W  write data.
REQ-011 SHALL have port inv  input  1  invalidate request for a single entry.
REQ-012 SHALL have port inv_addr  input  ADDR_W  entry to invalidate.
REQ-013 SHALL have port clr_all  input  1  invalidate all entries.
REQ-014 SHALL have port rd  input  RD_PORTS  per-port read request.
REQ-015 SHALL have port raddr  input  RD_PORTS*ADDR_W  per-port read address; port p uses bits [p*ADDR_W +: ADDR_W].
REQ-016 SHALL have port dout  output  RD_PORTS*DATA_W  per-port registered read data.
REQ-017 SHALL have port dout_v  output  RD_PORTS  per-port read-valid.
REQ-018 SHALL have port rd_err  output  RD_PORTS  per-port read error.
REQ-019 SHALL have port wr_err  output  1  write error.
REQ-020 SHALL have port valid_cnt  output  ADDR_W+1  number of currently valid entries.

Function
REQ-021 SHALL keep one data register and one valid bit per entry; a write to waddr < DATA_N stores din and sets the entry's valid bit at the next rising edge.
REQ-022 SHALL ignore a write with waddr >= DATA_N and assert wr_err for exactly one cycle, starting the cycle after the request; wr_err SHALL be 0 otherwise.
REQ-023 SHALL give each read port a read latency of 1 cycle: a request sampled at edge N drives dout/dout_v/rd_err from edge N onward, held for one cycle.
REQ-024 SHALL, for a read of a valid in-range entry, return dout = stored data, dout_v = 1, rd_err = 0.
REQ-025 SHALL, for a read of an invalid entry or of raddr >= DATA_N, return dout = 0, dout_v = 0, rd_err = 1.
REQ-026 SHALL, in any cycle after a cycle with rd[p] = 0, drive dout[p] = 0, dout_v[p] = 0, rd_err[p] = 0.
REQ-027 SHALL serve all read ports independently; any number of ports SHALL be able to read the same address in the same cycle.
REQ-028 SHALL, when a read and a legal write target the same address in one cycle and BYPASS = 1, return din with dout_v = 1.
REQ-029 SHALL, in the case of REQ-028 with BYPASS = 0, return the pre-write content and validity.
REQ-030 SHALL, for inv with inv_addr < DATA_N, clear that entry's valid bit at the next edge; out-of-range inv SHALL be ignored with no error.
REQ-031 SHALL, for clr_all, clear every valid bit at the next edge.
REQ-032 SHALL resolve same-cycle priority as: clr_all and inv are applied first, then a legal write; the written entry ends valid with din.
REQ-033 SHALL, under BYPASS = 1, apply forwarding per REQ-028 even when inv or clr_all is asserted in the same cycle.
REQ-034 SHALL update valid_cnt registered, equal to the population count of the valid bits after each edge, in the range 0..DATA_N, with no wrap.
REQ-035 SHALL NOT alter data registers on inv or clr_all; only validity changes.

Reset
REQ-036 SHALL, while resetn = 0, clear all valid bits, dout, dout_v, rd_err, wr_err and valid_cnt to 0 immediately, independent of clk.
REQ-037 SHALL NOT reset the data registers.
REQ-038 SHALL, on reset assertion mid-operation, discard any pending read result, with no dout_v pulse after resetn rises until a new read.

Verification
REQ-039 SHALL cover: after reset, read port 0 of address 3 -> next cycle dout = 0, dout_v = 0, rd_err = 1, valid_cnt = 0.
REQ-040 SHALL cover: write 0xA5 to address 2, then read it on ports 0 and 1 in the same cycle -> both ports give dout = 0xA5, dout_v = 1; valid_cnt = 1.
REQ-041 SHALL cover: with BYPASS = 1, write 0x3C to address 5 while port 1 reads address 5 -> next cycle dout[1] = 0x3C, dout_v[1] = 1; with BYPASS = 0 -> rd_err[1] = 1.
REQ-042 SHALL cover: DATA_N = 6, write to address 7 -> wr_err = 1 for one cycle, valid_cnt unchanged; read address 6 -> rd_err = 1.
REQ-043 SHALL cover: fill all 8 entries (valid_cnt = 8), then clr_all together with a write of 0x11 to address 0 -> valid_cnt = 1, read address 0 gives 0x11, read address 1 gives rd_err = 1.
REQ-044 SHALL cover: inv on address 4 with a write to address 4 in the same cycle -> entry 4 is valid with the new data; resetn pulsed low mid-read -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ff_array_mp.sv
// Multi-port register-file array with per-entry valid bits, write-to-read
// forwarding, single/all invalidate and a registered valid-entry count.
module ff_array_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_N   = 8,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            din,
  input  logic                         inv,
  input  logic [ADDR_W-1:0]            inv_addr,
  input  logic                         clr_all,
  input  logic [RD_PORTS-1:0]          rd,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   dout,
  output logic [RD_PORTS-1:0]          dout_v,
  output logic [RD_PORTS-1:0]          rd_err,
  output logic                         wr_err,
  output logic [ADDR_W:0]              valid_cnt
);

  localparam int unsigned LP_N = DATA_N;

  logic [DATA_W-1:0]          r_mem [DATA_N];
  logic [DATA_N-1:0]          r_valid;
  logic [ADDR_W:0]            r_cnt;
  logic                       r_wr_err;
  logic [RD_PORTS*DATA_W-1:0] r_dout;
  logic [RD_PORTS-1:0]        r_dout_v;
  logic [RD_PORTS-1:0]        r_rd_err;

  logic                       w_wr_ok;
  logic                       w_inv_ok;
  logic [DATA_N-1:0]          w_valid_nxt;
  logic [ADDR_W:0]            w_cnt;
  logic [ADDR_W-1:0]          w_ra     [RD_PORTS];
  logic [DATA_W-1:0]          w_rd_dat [RD_PORTS];
  logic                       w_rd_vld [RD_PORTS];

  // Invalidates are applied before the write so a same-cycle write wins.
  always_comb begin
    w_wr_ok     = wr  && (32'(waddr)    < LP_N);
    w_inv_ok    = inv && (32'(inv_addr) < LP_N);
    w_valid_nxt = r_valid;
    if (clr_all) begin
      w_valid_nxt = '0;
    end
    for (int unsigned e = 0; e < LP_N; e++) begin
      if (w_inv_ok && (inv_addr == ADDR_W'(e))) begin
        w_valid_nxt[e] = 1'b0;
      end
    end
    for (int unsigned e = 0; e < LP_N; e++) begin
      if (w_wr_ok && (waddr == ADDR_W'(e))) begin
        w_valid_nxt[e] = 1'b1;
      end
    end
    w_cnt = '0;
    for (int unsigned e = 0; e < LP_N; e++) begin
      w_cnt = w_cnt + (ADDR_W+1)'(w_valid_nxt[e]);
    end
  end

  // Out-of-range addresses match no entry and so read back as invalid.
  always_comb begin
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      w_ra[p]     = raddr[p*ADDR_W +: ADDR_W];
      w_rd_dat[p] = '0;
      w_rd_vld[p] = 1'b0;
      for (int unsigned e = 0; e < LP_N; e++) begin
        if (w_ra[p] == ADDR_W'(e)) begin
          w_rd_dat[p] = r_mem[e];
          w_rd_vld[p] = r_valid[e];
        end
      end
      if ((BYPASS != 0) && w_wr_ok && (waddr == w_ra[p])) begin
        w_rd_dat[p] = din;
        w_rd_vld[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < LP_N; e++) begin
      if (w_wr_ok && (waddr == ADDR_W'(e))) begin
        r_mem[e] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= '0;
      r_cnt    <= '0;
      r_wr_err <= 1'b0;
      r_dout   <= '0;
      r_dout_v <= '0;
      r_rd_err <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_cnt    <= w_cnt;
      r_wr_err <= wr && !w_wr_ok;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
        if (rd[p] && w_rd_vld[p]) begin
          r_dout[p*DATA_W +: DATA_W] <= w_rd_dat[p];
          r_dout_v[p]                <= 1'b1;
          r_rd_err[p]                <= 1'b0;
        end else begin
          r_dout[p*DATA_W +: DATA_W] <= '0;
          r_dout_v[p]                <= 1'b0;
          r_rd_err[p]                <= rd[p];
        end
      end
    end
  end

  assign dout      = r_dout;
  assign dout_v    = r_dout_v;
  assign rd_err    = r_rd_err;
  assign wr_err    = r_wr_err;
  assign valid_cnt = r_cnt;

endmodule

// File: tb/tb_ff_array_mp.sv
// Bench for ff_array_mp: three configurations driven in lockstep and checked
// every cycle against an array-level model, plus directed literal checks.
module tb_ff_array_mp;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] din = '0;
  logic       inv = 1'b0;
  logic [2:0] inv_addr = '0;
  logic       clr_all = 1'b0;
  logic [1:0] rd = '0;
  logic [5:0] raddr = '0;

  logic [15:0] g_dout [NI];
  logic [1:0]  g_dv   [NI];
  logic [1:0]  g_re   [NI];
  logic        g_we   [NI];
  logic [3:0]  g_cnt  [NI];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ff_array_mp #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .RD_PORTS(2), .BYPASS(1)) u0 (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din), .inv(inv),
    .inv_addr(inv_addr), .clr_all(clr_all), .rd(rd), .raddr(raddr),
    .dout(g_dout[0]), .dout_v(g_dv[0]), .rd_err(g_re[0]), .wr_err(g_we[0]),
    .valid_cnt(g_cnt[0]));

  ff_array_mp #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .RD_PORTS(2), .BYPASS(0)) u1 (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din), .inv(inv),
    .inv_addr(inv_addr), .clr_all(clr_all), .rd(rd), .raddr(raddr),
    .dout(g_dout[1]), .dout_v(g_dv[1]), .rd_err(g_re[1]), .wr_err(g_we[1]),
    .valid_cnt(g_cnt[1]));

  ff_array_mp #(.DATA_W(8), .ADDR_W(3), .DATA_N(6), .RD_PORTS(2), .BYPASS(1)) u2 (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din), .inv(inv),
    .inv_addr(inv_addr), .clr_all(clr_all), .rd(rd), .raddr(raddr),
    .dout(g_dout[2]), .dout_v(g_dv[2]), .rd_err(g_re[2]), .wr_err(g_we[2]),
    .valid_cnt(g_cnt[2]));

  function automatic int n_of(input int k);
    return (k == 2) ? 6 : 8;
  endfunction

  function automatic bit bp_of(input int k);
    return (k != 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: array contents and validity per configuration.
  logic [7:0]  m_mem [NI][8];
  bit          m_val [NI][8];
  logic [15:0] e_dout [NI];
  logic [1:0]  e_dv   [NI];
  logic [1:0]  e_re   [NI];
  logic        e_we   [NI];
  int          e_cnt  [NI];
  bit          m_wok;
  int          m_a;
  int          m_n;

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < NI; k++) begin
      if (!resetn) begin
        for (int i = 0; i < 8; i++) m_val[k][i] = 1'b0;
        e_dout[k] = '0;
        e_dv[k]   = '0;
        e_re[k]   = '0;
        e_we[k]   = 1'b0;
        e_cnt[k]  = 0;
      end else begin
        m_n   = n_of(k);
        m_wok = wr && (int'(waddr) < m_n);
        for (int p = 0; p < 2; p++) begin
          m_a = int'(raddr[p*3 +: 3]);
          e_dout[k][p*8 +: 8] = 8'h00;
          e_dv[k][p] = 1'b0;
          e_re[k][p] = 1'b0;
          if (rd[p]) begin
            if (m_a < m_n && bp_of(k) && m_wok && int'(waddr) == m_a) begin
              e_dout[k][p*8 +: 8] = din;
              e_dv[k][p] = 1'b1;
            end else if (m_a < m_n && m_val[k][m_a]) begin
              e_dout[k][p*8 +: 8] = m_mem[k][m_a];
              e_dv[k][p] = 1'b1;
            end else begin
              e_re[k][p] = 1'b1;
            end
          end
        end
        e_we[k] = wr && !m_wok;
        if (clr_all) for (int i = 0; i < 8; i++) m_val[k][i] = 1'b0;
        if (inv && int'(inv_addr) < m_n) m_val[k][inv_addr] = 1'b0;
        if (m_wok) begin
          m_mem[k][waddr] = din;
          m_val[k][waddr] = 1'b1;
        end
        e_cnt[k] = 0;
        for (int i = 0; i < 8; i++) e_cnt[k] += int'(m_val[k][i]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("u%0d.dout", k),      32'(g_dout[k]), 32'(e_dout[k]));
        chk($sformatf("u%0d.dout_v", k),    32'(g_dv[k]),   32'(e_dv[k]));
        chk($sformatf("u%0d.rd_err", k),    32'(g_re[k]),   32'(e_re[k]));
        chk($sformatf("u%0d.wr_err", k),    32'(g_we[k]),   32'(e_we[k]));
        chk($sformatf("u%0d.valid_cnt", k), 32'(g_cnt[k]),  32'(e_cnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; waddr = '0; din = '0; inv = 1'b0; inv_addr = '0;
    clr_all = 1'b0; rd = '0; raddr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.u%0d.dout", tag, k),   32'(g_dout[k]), 32'h0);
      chk($sformatf("%s.u%0d.dout_v", tag, k), 32'(g_dv[k]),   32'h0);
      chk($sformatf("%s.u%0d.rd_err", tag, k), 32'(g_re[k]),   32'h0);
      chk($sformatf("%s.u%0d.wr_err", tag, k), 32'(g_we[k]),   32'h0);
      chk($sformatf("%s.u%0d.cnt", tag, k),    32'(g_cnt[k]),  32'h0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    chk_en = 1'b1;

    // read of never-written entry
    rd = 2'b01; raddr = 6'd3; tick();
    chk("r039.dout0", 32'(g_dout[0][7:0]), 32'h00);
    chk("r039.dv0",   32'(g_dv[0][0]),     32'h0);
    chk("r039.re0",   32'(g_re[0][0]),     32'h1);
    chk("r039.cnt",   32'(g_cnt[0]),       32'h0);

    // write then dual-port read of the same entry
    idle(); wr = 1'b1; waddr = 3'd2; din = 8'hA5; tick();
    idle(); rd = 2'b11; raddr = {3'd2, 3'd2}; tick();
    chk("r040.dout0", 32'(g_dout[0][7:0]),  32'hA5);
    chk("r040.dout1", 32'(g_dout[0][15:8]), 32'hA5);
    chk("r040.dv",    32'(g_dv[0]),         32'h3);
    chk("r040.cnt",   32'(g_cnt[0]),        32'h1);

    // same-cycle write/read, bypass on and off
    idle(); wr = 1'b1; waddr = 3'd5; din = 8'h3C; rd = 2'b10; raddr = {3'd5, 3'd0}; tick();
    chk("r041.bp.dout1",   32'(g_dout[0][15:8]), 32'h3C);
    chk("r041.bp.dv1",     32'(g_dv[0][1]),      32'h1);
    chk("r041.nobp.re1",   32'(g_re[1][1]),      32'h1);
    chk("r041.nobp.dv1",   32'(g_dv[1][1]),      32'h0);
    chk("r041.n6.dout1",   32'(g_dout[2][15:8]), 32'h3C);
    idle(); rd = 2'b10; raddr = {3'd5, 3'd0}; tick();
    chk("r041.nobp.later", 32'(g_dout[1][15:8]), 32'h3C);

    // out-of-range write and read on DATA_N = 6
    idle(); wr = 1'b1; waddr = 3'd7; din = 8'h55; tick();
    chk("r042.we",     32'(g_we[2]),  32'h1);
    chk("r042.cnt",    32'(g_cnt[2]), 32'h2);
    chk("r042.u0.we",  32'(g_we[0]),  32'h0);
    idle(); tick();
    chk("r042.we.off", 32'(g_we[2]),  32'h0);
    rd = 2'b01; raddr = 6'd6; tick();
    chk("r042.re",     32'(g_re[2]),  32'h1);

    // fill, then clr_all with a same-cycle write
    for (int i = 0; i < 8; i++) begin
      idle(); wr = 1'b1; waddr = 3'(i); din = 8'h10 + 8'(i); tick();
    end
    chk("r043.full",    32'(g_cnt[0]), 32'h8);
    chk("r043.full.n6", 32'(g_cnt[2]), 32'h6);
    idle(); clr_all = 1'b1; wr = 1'b1; waddr = 3'd0; din = 8'h11; tick();
    chk("r043.cnt", 32'(g_cnt[0]), 32'h1);
    idle(); rd = 2'b11; raddr = {3'd1, 3'd0}; tick();
    chk("r043.dout0", 32'(g_dout[0][7:0]), 32'h11);
    chk("r043.dv",    32'(g_dv[0]),        32'h1);
    chk("r043.re",    32'(g_re[0]),        32'h2);

    // inv and write to the same entry, then inv alone
    idle(); inv = 1'b1; inv_addr = 3'd4; wr = 1'b1; waddr = 3'd4; din = 8'h77; tick();
    chk("r044.cnt", 32'(g_cnt[0]), 32'h2);
    idle(); rd = 2'b01; raddr = 6'd4; tick();
    chk("r044.dout0", 32'(g_dout[0][7:0]), 32'h77);
    chk("r044.dv0",   32'(g_dv[0][0]),     32'h1);
    idle(); inv = 1'b1; inv_addr = 3'd0; tick();
    chk("inv.cnt", 32'(g_cnt[0]), 32'h1);
    idle(); rd = 2'b01; raddr = 6'd0; tick();
    chk("inv.re0", 32'(g_re[0][0]), 32'h1);

    // forwarding survives clr_all; no-bypass sees pre-write state
    idle(); clr_all = 1'b1; wr = 1'b1; waddr = 3'd3; din = 8'h99; rd = 2'b01; raddr = 6'd3; tick();
    chk("clrbp.dout0",   32'(g_dout[0][7:0]), 32'h99);
    chk("clrbp.nobp.re", 32'(g_re[1][0]),     32'h1);
    idle(); wr = 1'b1; waddr = 3'd3; din = 8'h88; rd = 2'b11; raddr = {3'd3, 3'd3}; tick();
    chk("pre.bp.dout",   32'(g_dout[0]), 32'h8888);
    chk("pre.nobp.dout", 32'(g_dout[1]), 32'h9999);

    // asynchronous reset in the middle of a read
    idle(); rd = 2'b01; raddr = 6'd3; tick();
    chk("mid.dv0", 32'(g_dv[0][0]), 32'h1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("async");
    idle();
    @(posedge clk); #1 resetn = 1'b1;
    tick();
    chk("post.dv", 32'(g_dv[0]), 32'h0);
    tick();
    chk("post.dv2", 32'(g_dv[0]), 32'h0);

    for (int i = 0; i < 300; i++) begin
      wr       = 1'($urandom_range(0, 1));
      waddr    = 3'($urandom);
      din      = 8'($urandom);
      inv      = ($urandom_range(0, 3) == 0);
      inv_addr = 3'($urandom);
      clr_all  = ($urandom_range(0, 19) == 0);
      rd       = 2'($urandom);
      raddr    = 6'($urandom);
      tick();
    end
    idle(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
